// File: rtl/ser_to_par.sv
// TMDS receive deserializer: rebuilds 10-bit symbols from DDR bit pairs on clk_5x
// and bit-slips until control tokens repeat at one word offset.
module ser_to_par #(
   parameter int LOCK_CNT      = 8,
   parameter int SEARCH_WIN    = 2048,
   parameter int TOKEN_TIMEOUT = 65535
) (
   input  logic       clk_5x,
   input  logic       sys_rst_n,
   input  logic       data_rise,
   input  logic       data_fall,
   output logic [9:0] par_data,
   output logic       par_valid,
   output logic       locked,
   output logic [3:0] slip
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int SW = $clog2(SEARCH_WIN + 1);
   localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
   localparam logic [MW-1:0] MATCH_LIM = MW'(LOCK_CNT);
   localparam logic [SW-1:0] MISS_LIM  = SW'(SEARCH_WIN);
   localparam logic [TW-1:0] IDLE_LIM  = TW'(TOKEN_TIMEOUT);

   typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

   function automatic logic is_token(input logic [9:0] w);
      case (w)
         10'h354, 10'h0AB, 10'h154, 10'h2AB: is_token = 1'b1;
         default:                            is_token = 1'b0;
      endcase
   endfunction

   state_t        state_r;
   logic [19:0]   hist_r;
   logic [2:0]    phase_r;
   logic [3:0]    slip_r;
   logic [MW-1:0] match_cnt_r;
   logic [SW-1:0] miss_cnt_r;
   logic [TW-1:0] idle_cnt_r;
   logic [9:0]    par_data_r;
   logic          par_valid_r;
   logic          locked_r;

   logic [19:0]   shifted_s;
   logic [9:0]    cand_s;
   logic          tok_s;
   logic          tick_s;
   logic [MW-1:0] match_inc_s;
   logic [SW-1:0] miss_inc_s;
   logic [TW-1:0] idle_inc_s;

   // Window selection at the current slip plus saturating counter increments
   always_comb begin
      shifted_s   = hist_r >> (5'd10 - {1'b0, slip_r});
      cand_s      = shifted_s[9:0];
      tok_s       = is_token(cand_s);
      tick_s      = (phase_r == 3'd4);
      match_inc_s = (match_cnt_r >= MATCH_LIM) ? match_cnt_r : match_cnt_r + MW'(1);
      miss_inc_s  = (miss_cnt_r >= MISS_LIM) ? miss_cnt_r : miss_cnt_r + SW'(1);
      idle_inc_s  = (idle_cnt_r >= IDLE_LIM) ? idle_cnt_r : idle_cnt_r + TW'(1);
   end

   // Bit history, word phase, alignment FSM and registered symbol output
   always_ff @(posedge clk_5x or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= ST_SEARCH;
         hist_r      <= 20'h00000;
         phase_r     <= 3'd0;
         slip_r      <= 4'd0;
         match_cnt_r <= {MW{1'b0}};
         miss_cnt_r  <= {SW{1'b0}};
         idle_cnt_r  <= {TW{1'b0}};
         par_data_r  <= 10'h000;
         par_valid_r <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         hist_r      <= {data_fall, data_rise, hist_r[19:2]};
         phase_r     <= tick_s ? 3'd0 : phase_r + 3'd1;
         par_valid_r <= 1'b0;
         if (tick_s) begin
            par_data_r <= cand_s;
            case (state_r)
               ST_SEARCH: begin
                  if (tok_s) begin
                     miss_cnt_r <= {SW{1'b0}};
                     if (match_inc_s == MATCH_LIM) begin
                        state_r     <= ST_LOCKED;
                        locked_r    <= 1'b1;
                        par_valid_r <= 1'b1;
                        match_cnt_r <= {MW{1'b0}};
                     end else begin
                        match_cnt_r <= match_inc_s;
                     end
                  end else begin
                     match_cnt_r <= {MW{1'b0}};
                     if (miss_inc_s == MISS_LIM) begin
                        slip_r     <= (slip_r == 4'd9) ? 4'd0 : slip_r + 4'd1;
                        miss_cnt_r <= {SW{1'b0}};
                     end else begin
                        miss_cnt_r <= miss_inc_s;
                     end
                  end
               end
               ST_LOCKED: begin
                  // A token always wins over a timeout reached on the same tick
                  if (tok_s) begin
                     idle_cnt_r  <= {TW{1'b0}};
                     par_valid_r <= 1'b1;
                  end else if (idle_inc_s == IDLE_LIM) begin
                     state_r    <= ST_SEARCH;
                     locked_r   <= 1'b0;
                     idle_cnt_r <= {TW{1'b0}};
                  end else begin
                     idle_cnt_r  <= idle_inc_s;
                     par_valid_r <= 1'b1;
                  end
               end
               default: begin
                  state_r     <= ST_SEARCH;
                  locked_r    <= 1'b0;
                  match_cnt_r <= {MW{1'b0}};
                  miss_cnt_r  <= {SW{1'b0}};
                  idle_cnt_r  <= {TW{1'b0}};
               end
            endcase
         end
      end
   end

   assign par_data  = par_data_r;
   assign par_valid = par_valid_r;
   assign locked    = locked_r;
   assign slip      = slip_r;

endmodule

// File: tb/tb_ser_to_par.sv
// Bench for ser_to_par: table-driven lock scenarios, directed corner sequences and
// random streams compared every cycle against a bit-stream reference model.
module tb_ser_to_par;

   localparam int LOCK_CNT      = 8;
   localparam int SEARCH_WIN    = 4;
   localparam int TOKEN_TIMEOUT = 20;

   logic       clk_5x    = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic       data_rise = 1'b0;
   logic       data_fall = 1'b0;
   logic [9:0] par_data;
   logic       par_valid;
   logic       locked;
   logic [3:0] slip;

   ser_to_par #(
      .LOCK_CNT     (LOCK_CNT),
      .SEARCH_WIN   (SEARCH_WIN),
      .TOKEN_TIMEOUT(TOKEN_TIMEOUT)
   ) dut (
      .clk_5x   (clk_5x),
      .sys_rst_n(sys_rst_n),
      .data_rise(data_rise),
      .data_fall(data_fall),
      .par_data (par_data),
      .par_valid(par_valid),
      .locked   (locked),
      .slip     (slip)
   );

   always #5 clk_5x = ~clk_5x;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   bit tx_q[$];

   // reference model state: last 20 received bits, oldest first
   bit         hbits[$];
   int         m_edges, m_ticks, m_slip, m_match, m_miss, m_idle;
   bit         m_locked;
   logic [9:0] exp_data;
   logic       exp_valid, exp_locked;
   logic [3:0] exp_slip;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit token(input logic [9:0] w);
      return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
   endfunction

   task automatic model_reset();
      hbits.delete();
      for (int i = 0; i < 20; i++) hbits.push_back(1'b0);
      m_edges = 0; m_ticks = 0; m_slip = 0; m_match = 0; m_miss = 0; m_idle = 0;
      m_locked = 1'b0;
      exp_data = 10'h000; exp_valid = 1'b0; exp_locked = 1'b0; exp_slip = 4'd0;
   endtask

   task automatic model_step(input logic r, input logic f);
      logic [9:0] cand;
      bit tok;
      m_edges++;
      exp_valid = 1'b0;
      if (m_edges % 5 == 0) begin
         m_ticks++;
         for (int i = 0; i < 10; i++) cand[i] = hbits[10 - m_slip + i];
         tok = token(cand);
         if (!m_locked) begin
            if (tok) begin
               m_match++; m_miss = 0;
               if (m_match == LOCK_CNT) begin m_locked = 1'b1; m_match = 0; end
            end else begin
               m_match = 0; m_miss++;
               if (m_miss == SEARCH_WIN) begin m_slip = (m_slip + 1) % 10; m_miss = 0; end
            end
         end else if (tok) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == TOKEN_TIMEOUT) begin m_locked = 1'b0; m_idle = 0; end
         end
         exp_data  = cand;
         exp_valid = m_locked;
      end
      exp_locked = m_locked;
      exp_slip   = 4'(m_slip);
      hbits.push_back(r); hbits.push_back(f);
      void'(hbits.pop_front()); void'(hbits.pop_front());
   endtask

   task automatic drive_next();
      if (sys_rst_n && tx_q.size() >= 2) begin
         data_rise = tx_q.pop_front();
         data_fall = tx_q.pop_front();
      end else if (sys_rst_n && tx_q.size() == 1) begin
         data_rise = tx_q.pop_front();
         data_fall = 1'b0;
      end else begin
         data_rise = 1'b0;
         data_fall = 1'b0;
      end
   endtask

   task automatic cycle_check();
      check("cyc_par_data", 32'(par_data), 32'(exp_data));
      check("cyc_par_valid", 32'(par_valid), 32'(exp_valid));
      check("cyc_locked", 32'(locked), 32'(exp_locked));
      check("cyc_slip", 32'(slip), 32'(exp_slip));
   endtask

   always @(posedge clk_5x or negedge sys_rst_n)
      if (!sys_rst_n) model_reset();
      else model_step(data_rise, data_fall);

   always @(negedge clk_5x) drive_next();

   always @(negedge clk_5x)
      if (chk_en && sys_rst_n) cycle_check();

   task automatic push_zeros(input int n);
      for (int i = 0; i < n; i++) tx_q.push_back(1'b0);
   endtask

   task automatic push_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) tx_q.push_back(s[i]);
   endtask

   // async assert mid-cycle, outputs must clear with no clock edge
   task automatic do_reset();
      @(posedge clk_5x);
      #2 sys_rst_n = 1'b0;
      #1;
      check("rst_par_data", 32'(par_data), 32'h0);
      check("rst_par_valid", 32'(par_valid), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_slip", 32'(slip), 32'h0);
      tx_q.delete();
      repeat (2) @(posedge clk_5x);
   endtask

   task automatic release_rst();
      @(posedge clk_5x);
      #2 sys_rst_n = 1'b1;
   endtask

   task automatic wait_left(input int n, input string name);
      int g = 0;
      while (tx_q.size() > n && g < 10000) begin
         @(negedge clk_5x);
         g++;
      end
      check({name, "_drain"}, 32'(tx_q.size() <= n), 32'd1);
   endtask

   task automatic wait_tick(input int n, input string name);
      int g = 0;
      while (m_ticks < n && g < 2000) begin
         @(negedge clk_5x);
         g++;
      end
      check({name, "_tick"}, 32'(m_ticks), 32'(n));
   endtask

   typedef struct {
      int         pre;
      logic [9:0] sym;
      int         nsyms;
      logic       exp_locked;
      bit         chk_slip;
      logic [3:0] exp_slip;
      bit         chk_data;
   } vec_t;

   vec_t vecs[6];
   logic [9:0] toks[4];

   initial begin
      toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
      vecs[0] = '{8, 10'h354, 20, 1'b1, 1'b1, 4'd0, 1'b1};
      vecs[1] = '{5, 10'h354, 60, 1'b1, 1'b1, 4'd3, 1'b1};
      vecs[2] = '{8, 10'h0AB, 20, 1'b1, 1'b1, 4'd0, 1'b1};
      vecs[3] = '{6, 10'h154, 60, 1'b1, 1'b1, 4'd2, 1'b1};
      vecs[4] = '{8, 10'h1F0, 40, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[5] = '{1, 10'h2AB, 80, 1'b1, 1'b1, 4'd7, 1'b1};

      do_reset();
      chk_en = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_reset();
         push_zeros(vecs[i].pre);
         for (int k = 0; k < vecs[i].nsyms; k++) push_sym(vecs[i].sym);
         release_rst();
         wait_left(20, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
         if (vecs[i].chk_slip) check($sformatf("vec%0d_slip", i), 32'(slip), 32'(vecs[i].exp_slip));
         if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), 32'(par_data), 32'(vecs[i].sym));
      end

      // pass-through: 16 tokens then two data symbols, in transmit order
      do_reset();
      push_zeros(8);
      for (int k = 0; k < 16; k++) push_sym(10'h354);
      push_sym(10'h1F0); push_sym(10'h2A5);
      for (int k = 0; k < 4; k++) push_sym(10'h354);
      release_rst();
      wait_tick(8, "pt8");
      check("pt_unlocked_tick8", 32'(locked), 32'd0);
      wait_tick(9, "pt9");
      check("pt_lock_tick9", 32'(locked), 32'd1);
      check("pt_valid_tick9", 32'(par_valid), 32'd1);
      check("pt_data_tick9", 32'(par_data), 32'h354);
      wait_tick(18, "pt18");
      check("pt_valid_1f0", 32'(par_valid), 32'd1);
      check("pt_data_1f0", 32'(par_data), 32'h1F0);
      @(negedge clk_5x);
      check("pt_valid_gap", 32'(par_valid), 32'd0);
      wait_tick(19, "pt19");
      check("pt_valid_2a5", 32'(par_valid), 32'd1);
      check("pt_data_2a5", 32'(par_data), 32'h2A5);

      // loss of lock on the 20th consecutive non-token word
      do_reset();
      push_zeros(8);
      for (int k = 0; k < 10; k++) push_sym(10'h354);
      for (int k = 0; k < 25; k++) push_sym(10'h1F0);
      release_rst();
      wait_tick(30, "lol30");
      check("lol_locked_19th", 32'(locked), 32'd1);
      check("lol_valid_19th", 32'(par_valid), 32'd1);
      wait_tick(31, "lol31");
      check("lol_locked_20th", 32'(locked), 32'd0);
      check("lol_valid_20th", 32'(par_valid), 32'd0);
      check("lol_slip_kept", 32'(slip), 32'd0);

      // token on the would-be slip tick, then slip stepping and 9->0 wrap
      do_reset();
      push_zeros(8);
      push_sym(10'h1F0); push_sym(10'h1F0); push_sym(10'h354);
      for (int k = 0; k < 45; k++) push_sym(10'h1F0);
      release_rst();
      wait_tick(4, "pri4");
      check("pri_no_slip", 32'(slip), 32'd0);
      wait_tick(7, "pri7");
      check("pri_slip_hold", 32'(slip), 32'd0);
      wait_tick(8, "pri8");
      check("pri_slip_step", 32'(slip), 32'd1);
      wait_tick(43, "wrap43");
      check("wrap_slip9", 32'(slip), 32'd9);
      wait_tick(44, "wrap44");
      check("wrap_slip0", 32'(slip), 32'd0);

      // random streams: token runs mixed with random data, random start offset
      for (int r = 0; r < 3; r++) begin
         logic [9:0] t;
         do_reset();
         push_zeros($urandom_range(0, 19));
         t = toks[$urandom_range(0, 3)];
         for (int k = 0; k < 360; k++) begin
            if (k >= 120 && k < 170) push_sym(10'($urandom));
            else if ($urandom_range(0, 9) == 0) push_sym(10'($urandom));
            else push_sym(t);
         end
         release_rst();
         wait_left(0, $sformatf("rnd%0d", r));
      end

      do_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
